turn_scheduler: RTL and testbench

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/turn_scheduler_pkg.sv | 21 ++
 rtl/turn_timer.sv | 30 +++
 rtl/turn_scheduler.sv | 136 +++++++++++++
 tb/tb_turn_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_scheduler_pkg.sv
// Shared types and defaults for the two-player turn scheduler.
// State encoding is visible on the state output, so the values are fixed.
package turn_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    TURN     = 3'd2,
    GAMEOVER = 3'd3
  } state_t;

  typedef logic player_t;

  localparam int unsigned DEFAULT_TURN_TICKS = 30;
  localparam int unsigned DEFAULT_WIN_SCORE  = 5;

  function automatic logic [1:0] player_onehot(input player_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn tick counter; expire is combinational on the tick that reaches TURN_TICKS.
// A clear in the same cycle wins over an expiring tick and suppresses expire.
module turn_timer
  import turn_scheduler_pkg::*;
#(
  parameter int unsigned TURN_TICKS = DEFAULT_TURN_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  assign expire = enable && tick && !clear && (count == 8'(TURN_TICKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || clear || expire) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn FSM: loads the pattern, grants turns, scores rounds, detects the winner.
// All outputs registered; strobes are single-cycle pulses one cycle after their cause.
module turn_scheduler
  import turn_scheduler_pkg::*;
#(
  parameter int unsigned TURN_TICKS = DEFAULT_TURN_TICKS,
  parameter int unsigned WIN_SCORE  = DEFAULT_WIN_SCORE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [31:0] pattern_in,
  input  logic [1:0]  key_valid,
  input  logic [3:0]  key_note0,
  input  logic [3:0]  key_note1,
  input  logic        round_done,
  input  logic        miss,
  output logic [1:0]  turn,
  output logic        write_enable,
  output logic [31:0] data_out,
  output logic        answer_enable,
  output logic [3:0]  answer,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic        timeout,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  state_t     cur;
  player_t    player;
  logic       start_armed;
  logic       in_turn;
  logic       key_hit;
  logic       turn_end_rd;
  logic       expire;
  logic [3:0] key_note;
  logic [3:0] cur_score;
  logic [3:0] next_score;

  assign state       = cur;
  assign in_turn     = (cur == TURN);
  assign key_hit     = in_turn && key_valid[player];
  assign key_note    = player ? key_note1 : key_note0;
  assign turn_end_rd = in_turn && round_done;
  assign cur_score   = player ? score1 : score0;
  assign next_score  = (cur_score == 4'hF) ? cur_score : cur_score + 4'd1;

  // round_done is part of clear so it always masks a coincident expiring tick
  turn_timer #(
    .TURN_TICKS(TURN_TICKS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clear (key_hit || turn_end_rd),
    .enable(in_turn),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= IDLE;
      player        <= 1'b0;
      start_armed   <= 1'b0;
      turn          <= 2'b00;
      winner        <= 2'b00;
      write_enable  <= 1'b0;
      answer_enable <= 1'b0;
      timeout       <= 1'b0;
      answer        <= 4'h0;
      data_out      <= 32'h0;
      score0        <= 4'h0;
      score1        <= 4'h0;
    end else begin
      write_enable  <= 1'b0;
      answer_enable <= 1'b0;
      timeout       <= 1'b0;
      case (cur)
        IDLE: begin
          if (start) begin
            data_out <= pattern_in;
            player   <= 1'b0;
            cur      <= LOAD;
          end
        end
        LOAD: begin
          write_enable <= 1'b1;
          turn         <= player_onehot(player);
          cur          <= TURN;
        end
        TURN: begin
          if (key_hit) begin
            answer_enable <= 1'b1;
            answer        <= key_note;
          end
          if (round_done) begin
            turn <= 2'b00;
            if (!miss) begin
              if (player) score1 <= next_score;
              else        score0 <= next_score;
            end
            if (!miss && next_score == 4'(WIN_SCORE)) begin
              winner      <= player_onehot(player);
              start_armed <= 1'b0;
              cur         <= GAMEOVER;
            end else begin
              player <= ~player;
              cur    <= LOAD;
            end
          end else if (expire) begin
            turn    <= 2'b00;
            timeout <= 1'b1;
            player  <= ~player;
            cur     <= LOAD;
          end
        end
        GAMEOVER: begin
          // restart needs start to be seen low before it is honoured high again
          if (!start) begin
            start_armed <= 1'b1;
          end else if (start_armed) begin
            score0      <= 4'h0;
            score1      <= 4'h0;
            winner      <= 2'b00;
            start_armed <= 1'b0;
            cur         <= IDLE;
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized + directed bench for turn_scheduler with a turn-level reference model and scoreboard.
module tb_turn_scheduler;

  localparam int TT = 3;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, start, round_done, miss;
  logic [31:0] pattern_in;
  logic [1:0]  key_valid;
  logic [3:0]  key_note0, key_note1;
  logic [1:0]  turn, winner;
  logic        write_enable, answer_enable, timeout;
  logic [31:0] data_out;
  logic [3:0]  answer, score0, score1;
  logic [2:0]  state;

  turn_scheduler #(.TURN_TICKS(TT), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pattern_in(pattern_in),
    .key_valid(key_valid), .key_note0(key_note0), .key_note1(key_note1),
    .round_done(round_done), .miss(miss), .turn(turn), .write_enable(write_enable),
    .data_out(data_out), .answer_enable(answer_enable), .answer(answer),
    .score0(score0), .score1(score1), .timeout(timeout), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int stamp; logic [31:0] val; } ev_t;
  typedef struct {
    int stamp; logic [2:0] st; logic [1:0] turn; logic [3:0] s0; logic [3:0] s1;
    logic [1:0] win; logic [31:0] dout;
  } stat_t;

  ev_t   q_we[$], q_ans[$], q_to[$];
  stat_t q_stat[$];

  // Reference model: phase 0 idle, 1 loading, 2 player's turn, 3 game over
  int          m_phase, m_player, m_ticks, m_winner;
  int          m_score[2];
  bit          m_armed;
  logic [31:0] m_pattern;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_player = 0; m_ticks = 0; m_winner = 0;
    m_score[0] = 0; m_score[1] = 0; m_armed = 0; m_pattern = 32'h0;
  endtask

  task automatic model_step();
    int    stamp;
    bit    own_key;
    stat_t s;
    stamp = edge_cnt + 1;
    case (m_phase)
      0: if (start) begin m_pattern = pattern_in; m_player = 0; m_phase = 1; end
      1: begin q_we.push_back('{stamp, m_pattern}); m_ticks = 0; m_phase = 2; end
      2: begin
        own_key = key_valid[m_player];
        if (own_key) q_ans.push_back('{stamp, 32'(m_player == 1 ? key_note1 : key_note0)});
        if (round_done) begin
          if (!miss && m_score[m_player] < 15) m_score[m_player]++;
          if (!miss && m_score[m_player] == WS) begin
            m_winner = 1 << m_player; m_armed = 0; m_phase = 3;
          end else begin
            m_player = 1 - m_player; m_phase = 1;
          end
        end else if (own_key) begin
          m_ticks = 0;
        end else if (tick) begin
          m_ticks++;
          if (m_ticks == TT) begin
            q_to.push_back('{stamp, 32'h0});
            m_player = 1 - m_player; m_phase = 1;
          end
        end
      end
      default: begin
        if (!start) m_armed = 1;
        else if (m_armed) begin m_score[0] = 0; m_score[1] = 0; m_winner = 0; m_phase = 0; end
      end
    endcase
    s.stamp = stamp; s.st = 3'(m_phase);
    s.turn = (m_phase == 2) ? ((m_player == 1) ? 2'b10 : 2'b01) : 2'b00;
    s.s0 = 4'(m_score[0]); s.s1 = 4'(m_score[1]); s.win = 2'(m_winner); s.dout = m_pattern;
    q_stat.push_back(s);
  endtask

  task automatic cyc(input bit st, input logic [1:0] kv, input bit rd, input bit ms, input bit tk);
    start = st; key_valid = kv; round_done = rd; miss = ms; tick = tk;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_turn"}, 32'(turn), 0);
    chk({tag, "_winner"}, 32'(winner), 0);
    chk({tag, "_strobes"}, {29'h0, write_enable, answer_enable, timeout}, 0);
    chk({tag, "_answer"}, 32'(answer), 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_scores"}, {24'h0, score1, score0}, 0);
  endtask

  // Monitor: status every cycle, strobes whenever the DUT raises them
  always @(negedge clk) begin : monitor
    stat_t es;
    ev_t   ev;
    if (!reset) begin
      if (q_stat.size() != 0 && q_stat[0].stamp == edge_cnt) begin
        es = q_stat.pop_front();
        chk("state", 32'(state), 32'(es.st));
        chk("turn", 32'(turn), 32'(es.turn));
        chk("score0", 32'(score0), 32'(es.s0));
        chk("score1", 32'(score1), 32'(es.s1));
        chk("winner", 32'(winner), 32'(es.win));
        chk("data_out", data_out, es.dout);
      end
      while (q_we.size() != 0 && q_we[0].stamp < edge_cnt) begin
        ev = q_we.pop_front(); chk("write_enable_missing_at", edge_cnt, ev.stamp);
      end
      while (q_ans.size() != 0 && q_ans[0].stamp < edge_cnt) begin
        ev = q_ans.pop_front(); chk("answer_enable_missing_at", edge_cnt, ev.stamp);
      end
      while (q_to.size() != 0 && q_to[0].stamp < edge_cnt) begin
        ev = q_to.pop_front(); chk("timeout_missing_at", edge_cnt, ev.stamp);
      end
      if (write_enable) begin
        if (q_we.size() == 0) chk("write_enable_unexpected", 1, 0);
        else begin
          ev = q_we.pop_front();
          chk("write_enable_cycle", edge_cnt, ev.stamp);
          chk("write_enable_data", data_out, ev.val);
        end
      end
      if (answer_enable) begin
        if (q_ans.size() == 0) chk("answer_enable_unexpected", 1, 0);
        else begin
          ev = q_ans.pop_front();
          chk("answer_cycle", edge_cnt, ev.stamp);
          chk("answer_value", 32'(answer), ev.val);
        end
      end
      if (timeout) begin
        if (q_to.size() == 0) chk("timeout_unexpected", 1, 0);
        else begin
          ev = q_to.pop_front();
          chk("timeout_cycle", edge_cnt, ev.stamp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; tick = 0; start = 0; round_done = 0; miss = 0; key_valid = 2'b00;
    key_note0 = 4'h0; key_note1 = 4'h0; pattern_in = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Start with known pattern, then both players key at once: only player 0 counts
    pattern_in = 32'h8765_4321;
    cyc(1, 2'b00, 0, 0, 0);
    pattern_in = 32'hDEAD_BEEF;
    cyc(1, 2'b00, 1, 0, 0);            // round_done during LOAD is ignored
    key_note0 = 4'd3; key_note1 = 4'd9;
    cyc(1, 2'b11, 0, 0, 0);
    // Three ticks without keys: timeout, then player 1's turn
    cyc(1, 2'b00, 0, 0, 1);
    cyc(1, 2'b10, 0, 0, 1);            // non-active key does not reset the count
    cyc(1, 2'b00, 0, 0, 1);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    // Player 1 misses, player 0 scores, player 1 scores on the expiring tick
    cyc(1, 2'b00, 1, 1, 0);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 1, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 1);
    cyc(1, 2'b00, 0, 0, 1);
    cyc(1, 2'b00, 1, 0, 1);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    // Player 0 reaches the winning score
    cyc(1, 2'b00, 1, 0, 0);
    // Game over holds while start stays high, restarts on a fresh rising edge
    for (int i = 0; i < 3; i++) cyc(1, 2'b01, 1, 0, 1);
    cyc(0, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    pattern_in = 32'h0BAD_F00D;
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    key_note0 = 4'd7;
    cyc(1, 2'b01, 0, 0, 0);

    // Reset mid-turn with another key pending: nothing may survive the release
    key_valid = 2'b01;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero("midturn_reset");
    q_we.delete(); q_ans.delete(); q_to.delete(); q_stat.delete();
    model_reset();
    key_valid = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 2'b00, 0, 0, 1);

    // Randomized play
    for (int i = 0; i < 1500; i++) begin
      pattern_in = $urandom;
      key_note0  = 4'($urandom_range(0, 15));
      key_note1  = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 4) != 0,
          {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0},
          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    #1;
    chk("leftover_expected_events", 32'(q_we.size() + q_ans.size() + q_to.size() + q_stat.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
